bnn_conv_engine: RTL and testbench

Parametrised binary 3x3 convolution engine, the multi-kernel successor of the single-kernel XNOR/popcount convolver. It streams a sequence of bit-packed square binary images from the input SRAM and applies up to MAX_K weight kernels per image. Each kernel has its own popcount threshold. Every output row is written as one word to the output SRAM. It sits between the top-level run/busy handshake and the shared input/output SRAM and weight SRAM ports.

---
 rtl/bnn_conv_engine.sv | 196 +++++++++++++++++++
 tb/tb_bnn_conv_engine.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_conv_engine.sv
// Multi-kernel binary 3x3 XNOR/popcount convolver: streams bit-packed square
// images from SRAM, applies up to MAX_K thresholded kernels, one row word out per cycle.
module bnn_conv_engine #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int MAX_K  = 4
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              dut_sram_write_enable,
  output logic [ADDR_W-1:0] dut_wmem_read_address,
  input  logic [DATA_W-1:0] wmem_dut_read_data
);

  // state | meaning
  // IDLE  | waiting for dut_run
  // WLOAD | reading kernel count word and K kernel words
  // HDR   | reading image header (address cycle, then decode cycle)
  // FILL  | first three row reads of a kernel pass
  // OUT   | one output row per cycle, N-2 rows
  // DONE  | run finished, busy drops next cycle
  typedef enum logic [2:0] {S_IDLE, S_WLOAD, S_HDR, S_FILL, S_OUT, S_DONE} state_t;

  state_t state, state_nxt;

  logic [3:0]        w_addr, w_idx, k_num, k_raw, k_clamp;
  logic              w_dv, hph;
  logic [2:0]        k_idx;
  logic [8:0]        k_w [0:7];
  logic [3:0]        k_t [0:7];
  logic [ADDR_W-1:0] img_base, rd_addr, out_cnt, wr_addr, next_base;
  logic [4:0]        n_reg, cnt, hdr_n;
  logic              hdr_term, pass_end, more_k;
  logic [DATA_W-1:0] row_a, row_b, wr_data, conv;
  logic              wr_en;
  logic              unused_wmem;

  assign unused_wmem = ^wmem_dut_read_data[DATA_W-1:13];

  function automatic logic win_hit(input logic [8:0] win, input logic [8:0] w,
                                   input logic [3:0] t);
    logic [8:0] m;
    logic [3:0] pc;
    m  = ~(win ^ w);
    pc = '0;
    for (int j = 0; j < 9; j++) pc = pc + {3'b000, m[j]};
    return pc >= t;
  endfunction

  assign w_idx     = w_addr - 4'd1;
  assign k_raw     = wmem_dut_read_data[3:0];
  assign k_clamp   = (k_raw > 4'(MAX_K)) ? 4'(MAX_K) : k_raw;
  assign hdr_n     = sram_dut_read_data[4:0];
  assign hdr_term  = (sram_dut_read_data == DATA_W'(255)) || (hdr_n < 5'd3) ||
                     (int'(hdr_n) > DATA_W);
  assign pass_end  = (cnt == n_reg - 5'd3);
  assign more_k    = (({1'b0, k_idx} + 4'd1) < k_num);
  assign next_base = img_base + ADDR_W'(n_reg) + ADDR_W'(1);

  // Window rows: row_a = top, row_b = middle, incoming read data = bottom.
  always_comb begin
    conv = '0;
    for (int i = 0; i < DATA_W - 2; i++) begin
      if ((i + 2 < int'(n_reg)) &&
          win_hit({sram_dut_read_data[i +: 3], row_b[i +: 3], row_a[i +: 3]},
                  k_w[k_idx], k_t[k_idx]))
        conv[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (dut_run) state_nxt = S_WLOAD;
      S_WLOAD: begin
        if (w_dv) begin
          if (w_idx == 4'd0) begin
            if (k_raw == 4'd0) state_nxt = S_DONE;
          end else if (w_idx == k_num) begin
            state_nxt = S_HDR;
          end
        end
      end
      S_HDR:   if (hph) state_nxt = hdr_term ? S_DONE : S_FILL;
      S_FILL:  if (cnt == 5'd2) state_nxt = S_OUT;
      S_OUT:   if (pass_end) state_nxt = more_k ? S_FILL : S_HDR;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      w_addr   <= '0;
      w_dv     <= 1'b0;
      hph      <= 1'b0;
      k_num    <= '0;
      k_idx    <= '0;
      img_base <= '0;
      rd_addr  <= '0;
      out_cnt  <= '0;
      wr_addr  <= '0;
      n_reg    <= '0;
      cnt      <= '0;
      row_a    <= '0;
      row_b    <= '0;
      wr_data  <= '0;
      wr_en    <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        k_w[k] <= '0;
        k_t[k] <= '0;
      end
    end else begin
      wr_en <= 1'b0;
      w_dv  <= (state == S_WLOAD);
      hph   <= (state == S_HDR) && !hph;
      case (state)
        S_IDLE: begin
          if (dut_run) begin
            w_addr   <= '0;
            k_num    <= '0;
            img_base <= '0;
            rd_addr  <= '0;
            out_cnt  <= '0;
          end
        end
        S_WLOAD: begin
          w_addr <= w_addr + 4'd1;
          if (w_dv) begin
            if (w_idx == 4'd0) begin
              k_num <= k_clamp;
            end else if (w_idx <= k_num) begin
              k_w[3'(w_idx - 4'd1)] <= wmem_dut_read_data[8:0];
              k_t[3'(w_idx - 4'd1)] <= (wmem_dut_read_data[12:9] == 4'd0) ? 4'd5
                                       : wmem_dut_read_data[12:9];
            end
          end
        end
        S_HDR: begin
          if (hph && !hdr_term) begin
            n_reg   <= hdr_n;
            rd_addr <= img_base + ADDR_W'(1);
            k_idx   <= '0;
            cnt     <= '0;
          end
        end
        S_FILL: begin
          rd_addr <= rd_addr + ADDR_W'(1);
          row_a   <= row_b;
          row_b   <= sram_dut_read_data;
          cnt     <= (cnt == 5'd2) ? 5'd0 : cnt + 5'd1;
        end
        S_OUT: begin
          rd_addr <= rd_addr + ADDR_W'(1);
          row_a   <= row_b;
          row_b   <= sram_dut_read_data;
          wr_en   <= 1'b1;
          wr_data <= conv;
          wr_addr <= out_cnt;
          out_cnt <= out_cnt + ADDR_W'(1);
          cnt     <= cnt + 5'd1;
          if (pass_end) begin
            cnt <= '0;
            if (more_k) begin
              k_idx   <= k_idx + 3'd1;
              rd_addr <= img_base + ADDR_W'(1);
            end else begin
              img_base <= next_base;
              rd_addr  <= next_base;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dut_busy               = (state != S_IDLE);
  assign dut_sram_read_address  = rd_addr;
  assign dut_wmem_read_address  = ADDR_W'(w_addr);
  assign dut_sram_write_address = wr_addr;
  assign dut_sram_write_data    = wr_data;
  assign dut_sram_write_enable  = wr_en;

endmodule

// File: tb/tb_bnn_conv_engine.sv
// Directed bench for bnn_conv_engine: SRAM/weight memory models, write logging,
// hand-computed expectations plus a per-window reference for the random image.
module tb_bnn_conv_engine;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int MK = 4;

  logic          clk = 1'b0;
  logic          reset_b = 1'b1;
  logic          dut_run = 1'b0;
  logic          dut_busy;
  logic [AW-1:0] dut_sram_read_address;
  logic [DW-1:0] sram_dut_read_data = '0;
  logic [AW-1:0] dut_sram_write_address;
  logic [DW-1:0] dut_sram_write_data;
  logic          dut_sram_write_enable;
  logic [AW-1:0] dut_wmem_read_address;
  logic [DW-1:0] wmem_dut_read_data = '0;

  bnn_conv_engine #(.DATA_W(DW), .ADDR_W(AW), .MAX_K(MK)) dut (
    .clk                    (clk),
    .reset_b                (reset_b),
    .dut_run                (dut_run),
    .dut_busy               (dut_busy),
    .dut_sram_read_address  (dut_sram_read_address),
    .sram_dut_read_data     (sram_dut_read_data),
    .dut_sram_write_address (dut_sram_write_address),
    .dut_sram_write_data    (dut_sram_write_data),
    .dut_sram_write_enable  (dut_sram_write_enable),
    .dut_wmem_read_address  (dut_wmem_read_address),
    .wmem_dut_read_data     (wmem_dut_read_data)
  );

  always #5 clk = ~clk;

  logic [15:0] img_mem [0:4095];
  logic [15:0] wmem    [0:15];

  always @(posedge clk) begin
    sram_dut_read_data <= img_mem[dut_sram_read_address];
    wmem_dut_read_data <= wmem[dut_wmem_read_address[3:0]];
  end

  int wa[$];
  int wd[$];
  int exp_q[$];
  int bad_we = 0;
  int errors = 0;
  int checks = 0;

  always @(negedge clk) begin
    if (dut_sram_write_enable) begin
      wa.push_back(int'(dut_sram_write_address));
      wd.push_back(int'(dut_sram_write_data));
      if (!dut_busy) bad_we++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_count"}, wa.size(), exp_q.size());
    for (int i = 0; i < wa.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wa[i], i);
      chk($sformatf("%s_data%0d", tag, i), wd[i], exp_q[i]);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) img_mem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) wmem[i] = 16'h0000;
  endtask

  task automatic put_img(input int base, input int n, input logic [15:0] row_val);
    img_mem[base] = 16'(n);
    for (int r = 0; r < n; r++) img_mem[base + 1 + r] = row_val;
  endtask

  task automatic run_dut(input string tag, output int cyc);
    wa.delete();
    wd.delete();
    @(negedge clk) dut_run = 1'b1;
    @(negedge clk) dut_run = 1'b0;
    chk({tag, "_busy_rise"}, dut_busy, 1);
    cyc = 0;
    while (dut_busy && cyc < 3000) begin
      cyc++;
      @(negedge clk);
    end
    chk({tag, "_finish"}, (cyc < 3000), 1);
  endtask

  function automatic logic [15:0] golden(input int base, input int n, input logic [15:0] wt,
                                         input int r);
    logic [15:0] res;
    logic [15:0] row;
    int thr;
    int cnt;
    res = '0;
    thr = (wt[12:9] == 4'd0) ? 5 : int'(wt[12:9]);
    for (int i = 0; i < n - 2; i++) begin
      cnt = 0;
      for (int dr = 0; dr < 3; dr++) begin
        row = img_mem[base + 1 + r + dr];
        for (int dc = 0; dc < 3; dc++)
          if (wt[dr * 3 + dc] == row[i + dc]) cnt++;
      end
      if (cnt >= thr) res[i] = 1'b1;
    end
    return res;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n_at;
    int hi;
    logic [15:0] wt;

    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst_busy", dut_busy, 0);
    chk("rst_we", dut_sram_write_enable, 0);
    chk("rst_wdata", dut_sram_write_data, 0);
    chk("rst_raddr", dut_sram_read_address, 0);
    chk("rst_waddr", dut_sram_write_address, 0);
    chk("rst_wmaddr", dut_wmem_read_address, 0);
    reset_b = 1'b0;
    repeat (2) @(negedge clk);

    // All-ones 4x4, single all-ones kernel, majority threshold
    clear_mem();
    wmem[0] = 16'h0001; wmem[1] = 16'h01FF;
    put_img(0, 4, 16'h000F); img_mem[5] = 16'h00FF;
    run_dut("A", cyc);
    exp_q = '{3, 3};
    check_out("A");
    chk("A_cycles_le14", (cyc <= 14), 1);

    wmem[1] = 16'h0000;
    run_dut("B", cyc);
    exp_q = '{0, 0};
    check_out("B");

    wmem[1] = 16'h13FF; img_mem[2] = 16'h000D;
    run_dut("C9", cyc);
    exp_q = '{0, 0};
    check_out("C9");
    wmem[1] = 16'h11FF;
    run_dut("C8", cyc);
    exp_q = '{3, 3};
    check_out("C8");

    // Two kernels over two images, output order image/kernel/row
    clear_mem();
    wmem[0] = 16'h0002; wmem[1] = 16'h01FF; wmem[2] = 16'h0000;
    put_img(0, 4, 16'h000F); put_img(5, 4, 16'h000F); img_mem[10] = 16'h00FF;
    run_dut("D", cyc);
    exp_q = '{3, 3, 0, 0, 3, 3, 0, 0};
    check_out("D");
    chk("D_cycles_le41", (cyc <= 41), 1);

    // K=15 clamps to MAX_K=4; a fifth kernel would add two more writes
    clear_mem();
    wmem[0] = 16'h000F; wmem[1] = 16'h01FF; wmem[2] = 16'h0000;
    wmem[3] = 16'h01FF; wmem[4] = 16'h0000; wmem[5] = 16'h01FF;
    put_img(0, 4, 16'h000F); img_mem[5] = 16'h00FF;
    run_dut("E", cyc);
    exp_q = '{3, 3, 0, 0, 3, 3, 0, 0};
    check_out("E");

    // Smallest image: N=3 gives a single 1-bit row
    clear_mem();
    wmem[0] = 16'h0001; wmem[1] = 16'h01FF;
    put_img(0, 3, 16'h0007); img_mem[4] = 16'h00FF;
    run_dut("G", cyc);
    exp_q = '{1};
    check_out("G");

    // N=16 random image and kernel against the per-window reference
    clear_mem();
    wt = {3'b000, 4'($urandom_range(0, 9)), 9'($urandom)};
    wmem[0] = 16'h0001; wmem[1] = wt;
    img_mem[0] = 16'd16;
    for (int r = 0; r < 16; r++) img_mem[1 + r] = 16'($urandom);
    img_mem[17] = 16'h00FF;
    exp_q.delete();
    for (int r = 0; r < 14; r++) exp_q.push_back(int'(golden(0, 16, wt, r)));
    run_dut("F", cyc);
    check_out("F");
    hi = 0;
    foreach (wd[i]) hi = hi | (wd[i] >> 14);
    chk("F_hibits", hi, 0);

    // Terminator variants: 0x00FF first, N>DATA_W, and K=0
    clear_mem();
    wmem[0] = 16'h0001; wmem[1] = 16'h01FF;
    img_mem[0] = 16'h00FF;
    run_dut("H", cyc);
    chk("H_writes", wa.size(), 0);
    chk("H_cycles_le6", (cyc <= 6), 1);
    img_mem[0] = 16'd17;
    run_dut("H17", cyc);
    chk("H17_writes", wa.size(), 0);
    wmem[0] = 16'h0000;
    put_img(0, 4, 16'h000F); img_mem[5] = 16'h00FF;
    run_dut("K0", cyc);
    chk("K0_writes", wa.size(), 0);

    // dut_run pulses while busy must neither restart nor queue a run
    clear_mem();
    wmem[0] = 16'h0001; wmem[1] = 16'h01FF;
    put_img(0, 4, 16'h000F); img_mem[5] = 16'h00FF;
    wa.delete(); wd.delete();
    @(negedge clk) dut_run = 1'b1;
    @(negedge clk) dut_run = 1'b0;
    cyc = 0;
    while (dut_busy && cyc < 3000) begin
      dut_run = (cyc % 3 == 1);
      cyc++;
      @(negedge clk);
    end
    dut_run = 1'b0;
    chk("I_finish", (cyc < 3000), 1);
    exp_q = '{3, 3};
    check_out("I");
    n_at = 0;
    repeat (5) begin
      @(negedge clk);
      if (dut_busy) n_at++;
    end
    chk("I_no_restart", n_at, 0);

    // Reset in the middle of OUT, then a clean run
    clear_mem();
    wmem[0] = 16'h0001; wmem[1] = 16'h01FF;
    put_img(0, 16, 16'hFFFF); img_mem[17] = 16'h00FF;
    wa.delete(); wd.delete();
    @(negedge clk) dut_run = 1'b1;
    @(negedge clk) dut_run = 1'b0;
    cyc = 0;
    while (wa.size() < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("J_reached_out", (cyc < 200), 1);
    #1 reset_b = 1'b1;
    #1;
    chk("J_we", dut_sram_write_enable, 0);
    chk("J_busy", dut_busy, 0);
    chk("J_raddr", dut_sram_read_address, 0);
    chk("J_waddr", dut_sram_write_address, 0);
    chk("J_wmaddr", dut_wmem_read_address, 0);
    n_at = wa.size();
    @(negedge clk) reset_b = 1'b0;
    repeat (5) @(negedge clk);
    chk("J_no_writes", wa.size(), n_at);
    chk("J_idle", dut_busy, 0);

    clear_mem();
    wmem[0] = 16'h0001; wmem[1] = 16'h01FF;
    put_img(0, 4, 16'h000F); img_mem[5] = 16'h00FF;
    run_dut("J2", cyc);
    exp_q = '{3, 3};
    check_out("J2");

    chk("we_outside_busy", bad_we, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
